// File: rtl/miner_host_sequencer.sv
// miner_host_sequencer: host-side packet sequencer for the bitcoin-miner core.
// Loads a job, then walks the nonce range one LDNONCE pass at a time.
package miner_host_pkg;
    localparam int unsigned mask_length_gp = 3;

    typedef enum logic [1:0] {
        NET_OP_NULL = 2'd0,
        NET_OP_REG  = 2'd1,
        NET_OP_PC   = 2'd2,
        NET_OP_BAR  = 2'd3
    } net_op_e;

    typedef struct packed {
        net_op_e     op;
        logic [9:0]  id;
        logic [31:0] data;
        logic [9:0]  addr;
    } net_packet_s;
endpackage

module miner_host_sequencer
    import miner_host_pkg::*;
#(
    parameter logic [9:0]  NET_ID_P     = 10'd1,
    parameter logic [9:0]  CMD_ADDR_P   = 10'd20,
    parameter logic [9:0]  NONCE_ADDR_P = 10'd1,
    parameter logic [9:0]  MID_BASE_P   = 10'd1,
    parameter logic [9:0]  WORK_BASE_P  = 10'd9,
    parameter int unsigned SETTLE_P     = 2,
    parameter int unsigned GUARD_P      = 4,
    parameter logic [31:0] WATCHDOG_P   = 32'd1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [255:0]              midstate_i,
    input  logic [95:0]               work_i,
    input  logic [31:0]               nonce_start_i,
    input  logic [31:0]               nonce_end_i,
    input  logic [mask_length_gp-1:0] barrier_i,
    output net_packet_s               net_packet_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      found_o,
    output logic                      exhausted_o,
    output logic                      error_o,
    output logic [31:0]               nonce_o,
    output logic [31:0]               tries_o
);

    localparam logic [1:0]  CMD_LDWORK  = 2'd1;
    localparam logic [1:0]  CMD_LDNONCE = 2'd2;
    localparam logic [1:0]  CMD_DONE    = 2'd3;
    localparam logic [9:0]  IDLE_ADDR   = 10'd24;
    localparam logic [31:0] IDLE_DATA   = 32'hFFFF_FFFE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MID,
        S_WORK,
        S_NONCE,
        S_CMD,
        S_KICK,
        S_REL,
        S_WAIT,
        S_SETTLE,
        S_FIN
    } state_e;

    state_e      state_q;
    net_packet_s pkt_q;
    logic        busy_q;
    logic        done_q;
    logic        found_q;
    logic        exh_q;
    logic        err_q;
    logic        hit_q;
    logic [31:0] nonce_q;
    logic [31:0] tries_q;
    logic [31:0] end_q;
    logic [31:0] cnt_q;
    logic [255:0] ms_q;
    logic [95:0] wk_q;
    logic [2:0]  idx_q;
    logic [1:0]  cmd_q;

    logic [31:0] mid_word;
    logic [31:0] work_word;
    logic [1:0]  widx;

    // Word 0 sits in the most significant slice of each bus.
    assign widx      = 2'd2 - idx_q[1:0];
    assign mid_word  = ms_q[{~idx_q, 5'd0} +: 32];
    assign work_word = wk_q[{widx, 5'd0} +: 32];

    function automatic net_packet_s mk_pkt(
        input net_op_e     op,
        input logic [9:0]  addr,
        input logic [31:0] data
    );
        net_packet_s p;
        p.op   = op;
        p.id   = NET_ID_P;
        p.data = data;
        p.addr = addr;
        return p;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
            err_q   <= 1'b0;
            hit_q   <= 1'b0;
            nonce_q <= '0;
            tries_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            ms_q    <= '0;
            wk_q    <= '0;
            idx_q   <= '0;
            cmd_q   <= CMD_LDWORK;
        end else begin
            pkt_q  <= mk_pkt(NET_OP_NULL, IDLE_ADDR, IDLE_DATA);
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                        if (start_i && !busy_q && !abort_i) begin
                            ms_q    <= midstate_i;
                            wk_q    <= work_i;
                            end_q   <= nonce_end_i;
                            nonce_q <= nonce_start_i;
                            found_q <= 1'b0;
                            exh_q   <= 1'b0;
                            err_q   <= 1'b0;
                            hit_q   <= 1'b0;
                            tries_q <= '0;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                            cmd_q   <= CMD_LDWORK;
                            pkt_q   <= mk_pkt(NET_OP_BAR, IDLE_ADDR, 32'd7);
                            state_q <= S_MID;
                        end
                    end
                    S_MID: begin
                        pkt_q <= mk_pkt(NET_OP_REG,
                                        MID_BASE_P + {7'd0, idx_q},
                                        mid_word);
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            idx_q   <= '0;
                            state_q <= S_WORK;
                        end
                    end
                    S_WORK: begin
                        pkt_q <= mk_pkt(NET_OP_REG,
                                        WORK_BASE_P + {7'd0, idx_q},
                                        work_word);
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd2) begin
                            idx_q   <= '0;
                            state_q <= S_CMD;
                        end
                    end
                    S_NONCE: begin
                        pkt_q   <= mk_pkt(NET_OP_REG, NONCE_ADDR_P, nonce_q);
                        tries_q <= tries_q + 32'd1;
                        cmd_q   <= CMD_LDNONCE;
                        state_q <= S_CMD;
                    end
                    S_CMD: begin
                        pkt_q   <= mk_pkt(NET_OP_REG, CMD_ADDR_P, {30'd0, cmd_q});
                        state_q <= S_KICK;
                    end
                    S_KICK: begin
                        pkt_q   <= mk_pkt(NET_OP_PC, 10'd0, 32'd2);
                        state_q <= S_REL;
                    end
                    S_REL: begin
                        cnt_q   <= '0;
                        state_q <= (cmd_q == CMD_DONE) ? S_FIN : S_WAIT;
                    end
                    S_WAIT: begin
                        cnt_q <= cnt_q + 32'd1;
                        if (cnt_q >= 32'(GUARD_P) && barrier_i == '0) begin
                            hit_q   <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= S_SETTLE;
                        end else if (cnt_q >= 32'(GUARD_P) &&
                                     barrier_i == mask_length_gp'(1)) begin
                            hit_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_SETTLE;
                        end else if (cnt_q == WATCHDOG_P - 32'd1) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    S_SETTLE: begin
                        cnt_q <= cnt_q + 32'd1;
                        if (cnt_q == 32'(SETTLE_P) - 32'd1) begin
                            if (hit_q) begin
                                cmd_q   <= CMD_DONE;
                                state_q <= S_CMD;
                            end else if (cmd_q == CMD_LDWORK) begin
                                state_q <= S_NONCE;
                            end else if (nonce_q == end_q) begin
                                exh_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                nonce_q <= nonce_q + 32'd1;
                                state_q <= S_NONCE;
                            end
                        end
                    end
                    S_FIN: begin
                        found_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign net_packet_o = pkt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign found_o      = found_q;
    assign exhausted_o  = exh_q;
    assign error_o      = err_q;
    assign nonce_o      = nonce_q;
    assign tries_o      = tries_q;

endmodule
